// File: rtl/wb_tester_pkg.sv
// Shared types, widths and the test pattern generator for the Wishbone memory tester.
package wb_tester_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned ERR_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Word a of a sweep holds seed + a, wrapping modulo 2**32.
  function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] base,
                                                input logic [DATA_W-1:0] idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone bus bundle with initiator and target views.
interface wshb_if
  import wb_tester_pkg::*;
#(
  parameter int unsigned ADR_WIDTH = 11
) ();
  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [ADR_WIDTH-1:0] adr;
  logic [SEL_W-1:0]     sel;
  logic [DATA_W-1:0]    dat_ms;
  logic [DATA_W-1:0]    dat_sm;
  logic                 ack;

  modport master (output cyc, stb, we, adr, sel, dat_ms, input dat_sm, ack);
  modport slave  (input cyc, stb, we, adr, sel, dat_ms, output dat_sm, ack);
endinterface

// File: rtl/wb_tester_watchdog.sv
// Ack watchdog: counts consecutive stalled request cycles and flags the one that reaches TIMEOUT.
module wb_tester_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_stall,
  output logic o_expire_c
);
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_cnt;

  // Any cycle without a stall (ack seen or no request) restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_stall) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_expire_c = i_stall && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_mem_tester.sv
// Wishbone memory tester: writes seed+addr to every word, reads all back and counts mismatches.
// Defining WB_TESTER_TIMEOUT_EN adds an ack watchdog that aborts a stalled test.
module wb_mem_tester
  import wb_tester_pkg::*;
#(
  parameter int unsigned ADR_WIDTH = 11,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wshb_if.master               wb_m,
  input  logic                 start,
  input  logic [DATA_W-1:0]    seed,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [ADR_WIDTH-1:0] first_err_adr,
  output logic                 timeout
);
  localparam logic [ADR_WIDTH-1:0] ADR_LAST = '1;

  state_e               r_state, w_state_nxt;
  logic [ADR_WIDTH-1:0] r_adr, w_adr_nxt, w_adr_inc;
  logic [DATA_W-1:0]    r_seed, w_seed_nxt;
  logic                 r_cyc, w_cyc_nxt;
  logic                 r_stb, w_stb_nxt;
  logic                 r_we, w_we_nxt;
  logic [SEL_W-1:0]     r_sel, w_sel_nxt;
  logic [DATA_W-1:0]    r_dat, w_dat_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_pass, w_pass_nxt;
  logic [ERR_W-1:0]     r_err, w_err_nxt;
  logic [ADR_WIDTH-1:0] r_first, w_first_nxt;
  logic                 r_tmo, w_tmo_nxt;
  logic                 w_finish;
  logic                 w_ack;
  logic                 w_expire;
  logic [DATA_W-1:0]    w_exp_dat;

  // A stray ack outside a bus cycle must not advance anything.
  assign w_ack     = wb_m.ack & r_cyc;
  assign w_adr_inc = r_adr + ADR_WIDTH'(1);
  assign w_exp_dat = pattern(r_seed, DATA_W'(r_adr));

`ifdef WB_TESTER_TIMEOUT_EN
  wb_tester_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_stall    (r_cyc & r_stb & ~wb_m.ack),
    .o_expire_c (w_expire)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 32'd0);
  assign w_expire         = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_adr_nxt   = r_adr;
    w_seed_nxt  = r_seed;
    w_cyc_nxt   = r_cyc;
    w_stb_nxt   = r_stb;
    w_we_nxt    = r_we;
    w_sel_nxt   = r_sel;
    w_dat_nxt   = r_dat;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_pass_nxt  = r_pass;
    w_err_nxt   = r_err;
    w_first_nxt = r_first;
    w_tmo_nxt   = r_tmo;
    w_finish    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_WRITE;
          w_adr_nxt   = '0;
          w_seed_nxt  = seed;
          w_err_nxt   = '0;
          w_first_nxt = '0;
          w_tmo_nxt   = 1'b0;
          w_pass_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_cyc_nxt   = 1'b1;
          w_stb_nxt   = 1'b1;
          w_we_nxt    = 1'b1;
          w_sel_nxt   = '1;
          w_dat_nxt   = pattern(seed, '0);
        end
      end
      ST_WRITE: begin
        if (w_ack) begin
          if (r_adr == ADR_LAST) begin
            w_state_nxt = ST_READ;
            w_adr_nxt   = '0;
            w_we_nxt    = 1'b0;
            w_dat_nxt   = '0;
          end else begin
            w_adr_nxt = w_adr_inc;
            w_dat_nxt = pattern(r_seed, DATA_W'(w_adr_inc));
          end
        end
      end
      ST_READ: begin
        if (w_ack) begin
          if (wb_m.dat_sm != w_exp_dat) begin
            if (r_err == '0) w_first_nxt = r_adr;
            if (r_err != '1) w_err_nxt = r_err + ERR_W'(1);
          end
          if (r_adr == ADR_LAST) begin
            w_finish = 1'b1;
          end else begin
            w_adr_nxt = w_adr_inc;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_expire) begin
      w_finish  = 1'b1;
      w_tmo_nxt = 1'b1;
    end

    // Closing a test: release the bus and publish the verdict with the done pulse.
    if (w_finish) begin
      w_state_nxt = ST_DONE;
      w_cyc_nxt   = 1'b0;
      w_stb_nxt   = 1'b0;
      w_we_nxt    = 1'b0;
      w_sel_nxt   = '0;
      w_dat_nxt   = '0;
      w_adr_nxt   = '0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b1;
      w_pass_nxt  = (w_err_nxt == '0) && !w_tmo_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_adr   <= '0;
      r_seed  <= '0;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_dat   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_first <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_adr   <= w_adr_nxt;
      r_seed  <= w_seed_nxt;
      r_cyc   <= w_cyc_nxt;
      r_stb   <= w_stb_nxt;
      r_we    <= w_we_nxt;
      r_sel   <= w_sel_nxt;
      r_dat   <= w_dat_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_err   <= w_err_nxt;
      r_first <= w_first_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  assign wb_m.cyc      = r_cyc;
  assign wb_m.stb      = r_stb;
  assign wb_m.we       = r_we;
  assign wb_m.adr      = r_adr;
  assign wb_m.sel      = r_sel;
  assign wb_m.dat_ms   = r_dat;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_cnt       = r_err;
  assign first_err_adr = r_first;
  assign timeout       = r_tmo;

endmodule

// File: tb/tb_wb_mem_tester.sv
// Scoreboard bench for wb_mem_tester with a 16-word Wishbone RAM target model.
module tb_wb_mem_tester;
  import wb_tester_pkg::*;

  localparam int unsigned AW = 4;
  localparam int unsigned NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   seed = '0;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err_adr;

  always #5 clk = ~clk;

  wshb_if #(.ADR_WIDTH(AW)) wb ();

  wb_mem_tester #(
    .ADR_WIDTH (AW),
    .TIMEOUT   (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_m          (wb),
    .start         (start),
    .seed          (seed),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .first_err_adr (first_err_adr),
    .timeout       (timeout)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [31:0]   dat;
  } txn_t;

  typedef struct packed {
    logic          pass;
    logic [15:0]   err;
    logic [AW-1:0] first;
    logic          tmo;
  } res_t;

  txn_t q_txn[$];
  res_t q_res[$];
  int   n_chk = 0;
  int   n_bad = 0;
  int   n_stall = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RAM target: registered ack after sl_dly wait cycles, optional bit0 corruption of word 5.
  logic [31:0] mem [NW];
  logic        sl_ack;
  logic [31:0] sl_dat;
  int          sl_cnt;
  int          sl_dly = 0;
  bit          sl_never = 1'b0;
  bit          sl_corrupt = 1'b0;
  bit          spur_ack = 1'b0;

  assign wb.ack    = sl_ack | spur_ack;
  assign wb.dat_sm = sl_dat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_ack <= 1'b0;
      sl_cnt <= 0;
      sl_dat <= '0;
    end else if (wb.cyc && wb.stb && !sl_ack && !sl_never) begin
      if (sl_cnt >= sl_dly) begin
        sl_ack <= 1'b1;
        sl_cnt <= 0;
        if (wb.we) mem[wb.adr] <= wb.dat_ms;
        else sl_dat <= mem[wb.adr] ^ ((sl_corrupt && wb.adr == AW'(5)) ? 32'd1 : 32'd0);
      end else begin
        sl_cnt <= sl_cnt + 1;
      end
    end else begin
      sl_ack <= 1'b0;
    end
  end

  // Bus monitor: request stability while waiting, scoreboard pop on every ack.
  bit            have_req = 1'b0;
  logic [AW-1:0] h_adr;
  logic [31:0]   h_dat;
  logic          h_we;

  always @(negedge clk) begin
    txn_t t;
    if (rst_n && wb.cyc && wb.stb) begin
      if (have_req) begin
        check("hold_adr", 32'(wb.adr), 32'(h_adr));
        check("hold_dat", wb.dat_ms, h_dat);
        check("hold_we", 32'(wb.we), 32'(h_we));
      end else begin
        have_req = 1'b1;
        h_adr = wb.adr;
        h_dat = wb.dat_ms;
        h_we  = wb.we;
      end
      if (!wb.ack) n_stall++;
      if (wb.ack) begin
        have_req = 1'b0;
        if (q_txn.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          t = q_txn.pop_front();
          check("txn_we", 32'(wb.we), 32'(t.we));
          check("txn_adr", 32'(wb.adr), 32'(t.adr));
          check("txn_sel", 32'(wb.sel), 32'h0000_000F);
          if (t.we) check("txn_dat", wb.dat_ms, t.dat);
        end
      end
    end else begin
      have_req = 1'b0;
    end
  end

  task automatic push_sweep(input logic [31:0] s);
    txn_t t;
    for (int a = 0; a < int'(NW); a++) begin
      t.we = 1'b1; t.adr = AW'(a); t.dat = s + 32'(a);
      q_txn.push_back(t);
    end
    for (int a = 0; a < int'(NW); a++) begin
      t.we = 1'b0; t.adr = AW'(a); t.dat = '0;
      q_txn.push_back(t);
    end
  endtask

  task automatic push_result(input bit p, input int e, input int f, input bit tmo);
    res_t r;
    r.pass = p; r.err = 16'(e); r.first = AW'(f); r.tmo = tmo;
    q_res.push_back(r);
  endtask

  task automatic pulse_start(input logic [31:0] s);
    @(posedge clk); #1;
    seed  = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", 32'(busy), 32'd1);
    check("pass_low_busy", 32'(pass), 32'd0);
  endtask

  task automatic finish_test(input int budget);
    bit   seen;
    res_t r;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      r = q_res.pop_front();
      check("pass", 32'(pass), 32'(r.pass));
      check("err_cnt", 32'(err_cnt), 32'(r.err));
      check("first_err_adr", 32'(first_err_adr), 32'(r.first));
      check("timeout", 32'(timeout), 32'(r.tmo));
      check("busy_in_done", 32'(busy), 32'd0);
      check("cyc_in_done", 32'(wb.cyc), 32'd0);
      check("stb_in_done", 32'(wb.stb), 32'd0);
      check("sb_drained", 32'(q_txn.size()), 32'd0);
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
      check("pass_hold", 32'(pass), 32'(r.pass));
    end else begin
      q_res.delete();
      q_txn.delete();
    end
  endtask

  initial begin
    logic [31:0] wrap_exp [4];
    logic [31:0] s;
    bit          seen;
    wrap_exp[0] = 32'hFFFF_FFFE; wrap_exp[1] = 32'hFFFF_FFFF;
    wrap_exp[2] = 32'h0000_0000; wrap_exp[3] = 32'h0000_0001;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cyc", 32'(wb.cyc), 32'd0);
    check("rst_stb", 32'(wb.stb), 32'd0);
    check("rst_we", 32'(wb.we), 32'd0);
    check("rst_sel", 32'(wb.sel), 32'd0);
    check("rst_adr", 32'(wb.adr), 32'd0);
    check("rst_dat", wb.dat_ms, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_first", 32'(first_err_adr), 32'd0);
    check("rst_tmo", 32'(timeout), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Ack with no bus cycle open
    spur_ack = 1'b1;
    repeat (3) @(negedge clk);
    spur_ack = 1'b0;
    check("spur_busy", 32'(busy), 32'd0);
    check("spur_cyc", 32'(wb.cyc), 32'd0);
    check("spur_done", 32'(done), 32'd0);

    // Clean sweep
    push_sweep(32'h1000); push_result(1'b1, 0, 0, 1'b0);
    pulse_start(32'h1000);
    finish_test(200);
    for (int a = 0; a < int'(NW); a++) check("mem_clean", mem[a], 32'h1000 + 32'(a));

    // Word 5 corrupted on read
    sl_corrupt = 1'b1;
    push_sweep(32'h2000); push_result(1'b0, 1, 5, 1'b0);
    pulse_start(32'h2000);
    finish_test(200);
    sl_corrupt = 1'b0;

    // Seed wrapping past 2**32
    push_sweep(32'hFFFF_FFFE); push_result(1'b1, 0, 0, 1'b0);
    pulse_start(32'hFFFF_FFFE);
    finish_test(200);
    for (int a = 0; a < 4; a++) check("mem_wrap", mem[a], wrap_exp[a]);

    // Slow ack plus a start pulse while busy
    sl_dly = 3;
    push_sweep(32'h0BAD_0000); push_result(1'b1, 0, 0, 1'b0);
    pulse_start(32'h0BAD_0000);
    repeat (30) @(negedge clk);
    @(posedge clk); #1;
    seed = 32'hDEAD_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_test(600);
    repeat (4) @(negedge clk);
    check("quiet_busy", 32'(busy), 32'd0);
    check("quiet_cyc", 32'(wb.cyc), 32'd0);
    sl_dly = 0;

    // Reset while read of word 7 is pending
    push_sweep(32'h7000);
    pulse_start(32'h7000);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wb.cyc && wb.stb && !wb.we && wb.adr == AW'(7) && !wb.ack) begin
        seen = 1'b1;
        break;
      end
    end
    check("read7_reached", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_cyc", 32'(wb.cyc), 32'd0);
    check("arst_stb", 32'(wb.stb), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    q_txn.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_cyc", 32'(wb.cyc), 32'd0);
    check("post_rst_stb", 32'(wb.stb), 32'd0);
    check("post_rst_err", 32'(err_cnt), 32'd0);
    check("post_rst_done", 32'(done), 32'd0);

    // Normal sweep after reset with an arbitrary seed
    s = $urandom;
    push_sweep(s); push_result(1'b1, 0, 0, 1'b0);
    pulse_start(s);
    finish_test(200);

`ifdef WB_TESTER_TIMEOUT_EN
    // Target that never acks: watchdog aborts after 8 stalled cycles
    sl_never = 1'b1;
    n_stall = 0;
    push_result(1'b0, 0, 0, 1'b1);
    pulse_start(32'h55);
    finish_test(60);
    check("stall_cycles", 32'(n_stall), 32'd8);
    sl_never = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
